md_unit: RTL and testbench



---
 rtl/md_unit.sv | 224 ++++++++++++++++++++++
 tb/tb_md_unit.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// md_unit: iterative 32-bit multiply/divide unit with architectural HI/LO.
//
// Executes MULT/MULTU (radix-2 shift-add) and DIV/DIVU (radix-2 restoring)
// over 32 iterations, followed by one sign-correction/write-back cycle.
// MTHI/MTLO writes are accepted only while idle.
//
// Optional feature macro: MDU_FAST_MUL_EN
//   defined   : MULT/MULTU use a single-cycle 32x32 product and skip RUN.
//   undefined : every op takes the iterative path; no multiplier is inferred.
//
// Ports
//   clk    in   clock, all state changes on the rising edge
//   rst    in   synchronous active-high reset
//   start  in   request a new operation (sampled only when idle)
//   op     in   00 MULT, 01 MULTU, 10 DIV, 11 DIVU (sampled with start)
//   a      in   operand A / dividend (sampled with start)
//   b      in   operand B / divisor  (sampled with start)
//   hi_we  in   MTHI write enable (idle only)
//   lo_we  in   MTLO write enable (idle only)
//   wdata  in   MTHI/MTLO data
//   hi     out  HI register
//   lo     out  LO register
//   busy   out  operation in flight
//   done   out  one-cycle pulse after HI/LO take a result
module md_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  localparam int unsigned W  = 32;
  localparam int unsigned DW = 2 * W;
  localparam int unsigned CW = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  // Working registers. acc_q holds {partial product} for multiply and
  // {remainder, dividend/quotient} for divide.
  logic [DW-1:0] acc_q;
  logic [W-1:0]  opnd_q;    // multiplicand magnitude or divisor magnitude
  logic [W-1:0]  a_raw_q;   // unmodified dividend for the divide-by-zero result
  logic [CW-1:0] cnt_q;
  logic          is_div_q;
  logic          neg_lo_q;  // product sign (mul) or quotient sign (div)
  logic          neg_hi_q;  // remainder sign (div only)
  logic          div0_q;

  // Combinational helpers
  logic          sgn;
  logic [W-1:0]  a_mag;
  logic [W-1:0]  b_mag;
  logic [W:0]    mul_sum;
  logic [DW-1:0] mul_next;
  logic [W:0]    div_shift;
  logic [W:0]    div_trial;
  logic [DW-1:0] div_next;
  logic [DW-1:0] prod_fix;
  logic [W-1:0]  fix_hi;
  logic [W-1:0]  fix_lo;

`ifdef MDU_FAST_MUL_EN
  logic [DW-1:0] fast_a;
  logic [DW-1:0] fast_b;
  logic [DW-1:0] fast_prod;

  // One multiplier serves both MULT and MULTU: sign-extend only for MULT,
  // the low 64 bits of the 64x64 product are then the correct result.
  always_comb begin
    fast_a    = {{W{a[W-1] & ~op[0]}}, a};
    fast_b    = {{W{b[W-1] & ~op[0]}}, b};
    fast_prod = fast_a * fast_b;
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
`ifdef MDU_FAST_MUL_EN
          state_d = op[1] ? ST_RUN : ST_FIX;
`else
          state_d = ST_RUN;
`endif
        end
      end
      ST_RUN: begin
        if (cnt_q == CW'(W - 1)) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand magnitudes taken at start (signed ops only)
  always_comb begin
    sgn   = ~op[0];
    a_mag = (sgn && a[W-1]) ? (~a + W'(1)) : a;
    b_mag = (sgn && b[W-1]) ? (~b + W'(1)) : b;
  end

  // One shift-add multiply step: conditional add into the upper half,
  // then shift the whole accumulator right with the adder carry.
  always_comb begin
    mul_sum  = {1'b0, acc_q[DW-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : (W + 1)'(0));
    mul_next = {mul_sum, acc_q[W-1:1]};
  end

  // One restoring divide step: shift the next dividend bit into the
  // remainder and keep the trial difference only when it did not borrow.
  always_comb begin
    div_shift = {acc_q[DW-1:W], acc_q[W-1]};
    div_trial = div_shift - {1'b0, opnd_q};
    if (div_trial[W]) begin
      div_next = {div_shift[W-1:0], acc_q[W-2:0], 1'b0};
    end else begin
      div_next = {div_trial[W-1:0], acc_q[W-2:0], 1'b1};
    end
  end

  // Sign correction and result placement used in FIX
  always_comb begin
    prod_fix = neg_lo_q ? (~acc_q + DW'(1)) : acc_q;
    fix_hi   = prod_fix[DW-1:W];
    fix_lo   = prod_fix[W-1:0];
    if (is_div_q) begin
      if (div0_q) begin
        fix_lo = '1;
        fix_hi = a_raw_q;
      end else begin
        fix_lo = neg_lo_q ? (~acc_q[W-1:0] + W'(1))  : acc_q[W-1:0];
        fix_hi = neg_hi_q ? (~acc_q[DW-1:W] + W'(1)) : acc_q[DW-1:W];
      end
    end
  end

  // Datapath, HI/LO and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      acc_q    <= '0;
      opnd_q   <= '0;
      a_raw_q  <= '0;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      busy <= (state_d != ST_IDLE);
      done <= (state_q == ST_FIX);
      case (state_q)
        ST_IDLE: begin
          // MTHI/MTLO land even on a start edge; FIX overwrites later.
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            is_div_q <= op[1];
            a_raw_q  <= a;
            div0_q   <= (b == '0);
            cnt_q    <= '0;
            neg_lo_q <= sgn & (a[W-1] ^ b[W-1]);
            neg_hi_q <= sgn & a[W-1];
            if (op[1]) begin
              acc_q  <= {{W{1'b0}}, a_mag};
              opnd_q <= b_mag;
            end else begin
`ifdef MDU_FAST_MUL_EN
              acc_q    <= fast_prod;
              opnd_q   <= a_mag;
              neg_lo_q <= 1'b0;
`else
              acc_q  <= {{W{1'b0}}, b_mag};
              opnd_q <= a_mag;
`endif
            end
          end
        end
        ST_RUN: begin
          acc_q <= is_div_q ? div_next : mul_next;
          cnt_q <= cnt_q + CW'(1);
        end
        ST_FIX: begin
          hi <= fix_hi;
          lo <= fix_lo;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed steps plus a short random run,
// expected HI/LO pushed at start and compared when done pulses.
module tb_md_unit;

`ifdef MDU_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          id;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   op_id  = 0;

  md_unit dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .hi    (hi),
    .lo    (lo),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: {hi, lo} for one operation
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x,
                                        input logic [31:0] y);
    logic [63:0] p;
    int          sx;
    int          sy;
    logic [31:0] q;
    logic [31:0] r;
    p = '0;
    case (o)
      OP_MULT:  p = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
      OP_MULTU: p = {32'd0, x} * {32'd0, y};
      OP_DIV: begin
        if (y == 32'd0) p = {x, 32'hFFFF_FFFF};
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) p = {32'd0, 32'h8000_0000};
        else begin
          sx = x;
          sy = y;
          q  = 32'(sx / sy);
          r  = 32'(sx % sy);
          p  = {r, q};
        end
      end
      default: begin
        if (y == 32'd0) p = {x, 32'hFFFF_FFFF};
        else p = {x % y, x / y};
      end
    endcase
    return p;
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding op
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      n_cmp++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL done_pulse: observed=done with no op outstanding expected=no done");
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk($sformatf("sb_hi[%0d]", e.id), hi, e.hi);
        chk($sformatf("sb_lo[%0d]", e.id), lo, e.lo);
      end
    end
  end

  // Start one op at a negedge and return at the negedge where done is seen.
  // poke 1: pulse start+hi_we mid-run; poke 2: check the MTLO issued with start.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [63:0] ex, input int poke);
    int k;
    int expl;
    expl = (!o[1] && FAST) ? 1 : 33;
    sb.push_back('{ex[63:32], ex[31:0], op_id});
    op_id++;
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(negedge clk);
    start = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    op    = 2'($urandom);
    a     = $urandom;
    b     = $urandom;
    chk("busy_after_start", 32'(busy), 32'd1);
    if (poke == 2) chk("mtlo_with_start", lo, 32'h77);
    k = 0;
    while (done !== 1'b1 && k < 60) begin
      if (poke == 1 && k == 10) begin
        start = 1'b1;
        op    = OP_MULT;
        a     = 32'd3;
        b     = 32'd3;
        hi_we = 1'b1;
        wdata = 32'h55;
      end else begin
        start = 1'b0;
        hi_we = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    hi_we = 1'b0;
    chk("latency", 32'(k), 32'(expl));
    chk("busy_at_done", 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]  ro;
    logic [31:0] rx;
    logic [31:0] ry;

    rst   = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    wdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // MTHI/MTLO in idle, visible one cycle after the write edge
    hi_we = 1'b1;
    lo_we = 1'b1;
    wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    hi_we = 1'b0;
    lo_we = 1'b0;
    chk("mthi_idle", hi, 32'hDEAD_BEEF);
    chk("mtlo_idle", lo, 32'hDEAD_BEEF);

    // Reset three cycles into an op aborts it (fast build uses a divide so
    // the op is still in flight when reset arrives)
    start = 1'b1;
    op    = FAST ? OP_DIVU : OP_MULT;
    a     = 32'd5;
    b     = 32'd3;
    @(negedge clk);
    start = 1'b0;
    chk("abort_busy_before", 32'(busy), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    repeat (40) @(negedge clk);
    chk("abort_still_idle", 32'(busy), 32'd0);

    run_op(OP_MULTU, 32'd7, 32'd6, {32'd0, 32'd42}, 0);
    run_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, {32'hFFFF_FFFF, 32'hFFFF_FFFA}, 0);
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001}, 0);
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 0);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 0);
    run_op(OP_DIVU, 32'h0000_1234, 32'd0, {32'h0000_1234, 32'hFFFF_FFFF}, 0);
    run_op(OP_DIV, 32'hFFFF_FFFB, 32'd0, {32'hFFFF_FFFB, 32'hFFFF_FFFF}, 0);

    // start and MTHI while busy are dropped
    run_op(OP_DIVU, 32'd100, 32'd7, {32'd2, 32'd14}, 1);
    repeat (3) @(negedge clk);
    chk("no_queued_start", 32'(busy), 32'd0);

    // MTLO on the start edge lands, then FIX overwrites both
    lo_we = 1'b1;
    wdata = 32'h77;
    run_op(OP_DIVU, 32'd9, 32'd2, {32'd1, 32'd4}, 2);

    // MTLO in idle right on the done cycle
    lo_we = 1'b1;
    wdata = 32'hA5;
    @(negedge clk);
    lo_we = 1'b0;
    chk("mtlo_after_op_lo", lo, 32'hA5);
    chk("mtlo_after_op_hi", hi, 32'd1);

    // Back-to-back random ops, each started on the done cycle of the last
    for (int i = 0; i < 8; i++) begin
      ro = 2'($urandom_range(0, 3));
      rx = $urandom;
      ry = (i % 3 == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      if (i % 4 == 1) rx = -rx;
      run_op(ro, rx, ry, model(ro, rx, ry), 0);
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    chk("final_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
